// File: rtl/seq_shift_unit_pkg.sv
// Shared types for the iterative shift unit: operation codes, FSM states
// and a small decode helper.
package shift_pkg;

    typedef enum logic [2:0] {
        LSR = 3'b000,
        ASR = 3'b001,
        ROR = 3'b010,
        LSL = 3'b100,
        ASL = 3'b101,
        ROL = 3'b110
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } fsm_state_t;

    function automatic logic is_asl(input logic [2:0] op);
        return (op == ASL);
    endfunction

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response handshake bundle of the iterative shift unit.
interface seq_shift_unit_if #(
    parameter int D_SIZE = 8
);
    localparam int S_W = $clog2(D_SIZE);

    logic                req_valid_in;
    logic                req_ready_out;
    logic [D_SIZE-1:0]   x_in;
    logic [S_W-1:0]      s_in;
    logic [2:0]          op_in;
    logic                resp_valid_out;
    logic                resp_ready_in;
    logic [D_SIZE-1:0]   y_out;
    logic                zf_out;
    logic                vf_out;

    modport master (
        output req_valid_in, x_in, s_in, op_in, resp_ready_in,
        input  req_ready_out, resp_valid_out, y_out, zf_out, vf_out
    );

    modport slave (
        input  req_valid_in, x_in, s_in, op_in, resp_ready_in,
        output req_ready_out, resp_valid_out, y_out, zf_out, vf_out
    );

endinterface

// File: rtl/seq_shift_unit_step.sv
// Single-position shift for one operation, plus the ASL overflow bit of that step.
module shift_step
    import shift_pkg::*;
#(
    parameter int D_SIZE = 8
) (
    input  logic [D_SIZE-1:0] y,
    input  logic [2:0]        op,
    output logic [D_SIZE-1:0] y_next,
    output logic              ovf_step
);

    // One bit position of the selected shift/rotate
    always_comb begin
        y_next   = y;
        ovf_step = 1'b0;
        case (op)
            LSR:           y_next = {1'b0, y[D_SIZE-1:1]};
            ASR:           y_next = {y[D_SIZE-1], y[D_SIZE-1:1]};
            ROR, 3'b011:   y_next = {y[0], y[D_SIZE-1:1]};
            LSL:           y_next = {y[D_SIZE-2:0], 1'b0};
            ASL: begin
                // sign bit stays put; overflow when the bit moving under it differs
                y_next   = {y[D_SIZE-1], y[D_SIZE-3:0], 1'b0};
                ovf_step = y[D_SIZE-2] ^ y[D_SIZE-1];
            end
            ROL, 3'b111:   y_next = {y[D_SIZE-2:0], y[D_SIZE-1]};
            default: begin
                y_next   = y;
                ovf_step = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative handshaked shifter: accepts a command, shifts one position per
// clock, then presents result and flags until the consumer takes them.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int D_SIZE = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    seq_shift_unit_if.slave  bus
);

    localparam int S_W = $clog2(D_SIZE);

    fsm_state_t          state_r, state_s;
    logic [D_SIZE-1:0]   work_r, work_s;
    logic [2:0]          op_r, op_s;
    logic [S_W-1:0]      cnt_r, cnt_s;
    logic                vacc_r, vacc_s;
    logic                load_out_s;
    logic                req_ready_r;
    logic                resp_valid_r;
    logic [D_SIZE-1:0]   y_r;
    logic                zf_r;
    logic                vf_r;
    logic [D_SIZE-1:0]   step_y_s;
    logic                step_ovf_s;

    shift_step #(.D_SIZE(D_SIZE)) u_step (
        .y        (work_r),
        .op       (op_r),
        .y_next   (step_y_s),
        .ovf_step (step_ovf_s)
    );

    // Next-state and datapath decode
    always_comb begin
        state_s    = state_r;
        work_s     = work_r;
        op_s       = op_r;
        cnt_s      = cnt_r;
        vacc_s     = vacc_r;
        load_out_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid_in && req_ready_r) begin
                    work_s = bus.x_in;
                    op_s   = bus.op_in;
                    cnt_s  = bus.s_in;
                    vacc_s = 1'b0;
                    if (bus.s_in == {S_W{1'b0}}) begin
                        state_s    = DONE;
                        load_out_s = 1'b1;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                work_s = step_y_s;
                vacc_s = vacc_r | step_ovf_s;
                cnt_s  = cnt_r - S_W'(1);
                if (cnt_r == S_W'(1)) begin
                    state_s    = DONE;
                    load_out_s = 1'b1;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.resp_ready_in && resp_valid_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, working registers and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r      <= IDLE;
            work_r       <= {D_SIZE{1'b0}};
            op_r         <= 3'b000;
            cnt_r        <= {S_W{1'b0}};
            vacc_r       <= 1'b0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            y_r          <= {D_SIZE{1'b0}};
            zf_r         <= 1'b0;
            vf_r         <= 1'b0;
        end else begin
            state_r      <= state_s;
            work_r       <= work_s;
            op_r         <= op_s;
            cnt_r        <= cnt_s;
            vacc_r       <= vacc_s;
            req_ready_r  <= (state_s == IDLE);
            // valid rises one cycle after entering DONE, drops on the handshake edge
            resp_valid_r <= (state_s == DONE) && (state_r == DONE);
            if (load_out_s) begin
                y_r  <= work_s;
                zf_r <= (work_s == {D_SIZE{1'b0}});
                vf_r <= is_asl(op_s) & vacc_s;
            end else begin
                y_r  <= y_r;
                zf_r <= zf_r;
                vf_r <= vf_r;
            end
        end
    end

    assign bus.req_ready_out  = req_ready_r;
    assign bus.resp_valid_out = resp_valid_r;
    assign bus.y_out          = y_r;
    assign bus.zf_out         = zf_r;
    assign bus.vf_out         = vf_r;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit at D_SIZE=8: expectations are queued
// when a command is driven and compared when the response appears.
module tb_seq_shift_unit;

    localparam int D = 8;

    typedef struct packed {
        logic [D-1:0] y;
        logic         zf;
        logic         vf;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_shift_unit_if #(.D_SIZE(D)) bus ();
    seq_shift_unit #(.D_SIZE(D)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    resp_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic resp_t mk(input logic [7:0] y, input logic zf, input logic vf);
        resp_t r;
        r.y  = y;
        r.zf = zf;
        r.vf = vf;
        return r;
    endfunction

    // Reference: whole shift at once, vf from the top s+1 bits of x
    function automatic resp_t model(input logic [7:0] x, input int s, input logic [2:0] op);
        logic [15:0] w;
        logic [7:0]  y;
        logic [7:0]  top;
        logic        vf;
        vf = 1'b0;
        case (op)
            3'b000:         y = x >> s;
            3'b001:         y = 8'($signed(x) >>> s);
            3'b010, 3'b011: begin w = {x, x} >> s; y = w[7:0]; end
            3'b100:         y = x << s;
            3'b101: begin
                y   = {x[7], 7'(x[6:0] << s)};
                top = x >> (7 - s);
                vf  = (s > 0) && (top != 8'd0) && (top != 8'((16'd1 << (s + 1)) - 16'd1));
            end
            default: begin w = {x, x} << s; y = w[15:8]; end
        endcase
        return mk(y, (y == 8'd0), vf);
    endfunction

    task automatic send(input logic [7:0] x, input int s, input logic [2:0] op, output bit ok);
        ok = 1'b0;
        bus.req_valid_in = 1'b1;
        bus.x_in  = x;
        bus.s_in  = 3'(s);
        bus.op_in = op;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept: req_ready_out=%b, required 1 within 20 cycles", bus.req_ready_out);
        end
        @(posedge clk);
        #1;
        bus.req_valid_in = 1'b0;
        bus.x_in  = ~x;
        bus.s_in  = ~3'(s);
        bus.op_in = ~op;
    endtask

    task automatic wait_and_check(input int s, input string name);
        int    lat;
        resp_t exp;
        lat = 0;
        while (bus.resp_valid_out !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat - 1 != s + 1) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat - 1, s + 1);
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: queue empty, required one entry", name);
        end else begin
            exp = sb.pop_front();
            checks++;
            if (bus.y_out !== exp.y) begin
                failures++;
                $display("FAIL %s_y: got %h, required %h", name, bus.y_out, exp.y);
            end
            checks++;
            if (bus.zf_out !== exp.zf) begin
                failures++;
                $display("FAIL %s_zf: got %b, required %b", name, bus.zf_out, exp.zf);
            end
            checks++;
            if (bus.vf_out !== exp.vf) begin
                failures++;
                $display("FAIL %s_vf: got %b, required %b", name, bus.vf_out, exp.vf);
            end
        end
    endtask

    task automatic handshake(input string name);
        bus.resp_ready_in = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready_in = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.resp_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL %s_valid_drop: got %b, required 0", name, bus.resp_valid_out);
        end
        checks++;
        if (bus.req_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_back: got %b, required 1", name, bus.req_ready_out);
        end
    endtask

    task automatic run_op(input logic [7:0] x, input int s, input logic [2:0] op,
                          input resp_t exp, input string name);
        bit ok;
        sb.push_back(exp);
        send(x, s, op, ok);
        if (ok) begin
            wait_and_check(s, name);
            handshake(name);
        end else begin
            sb.delete();
        end
    endtask

    task automatic test_reset();
        bus.req_valid_in  = 1'b0;
        bus.resp_ready_in = 1'b0;
        bus.x_in  = 8'h00;
        bus.s_in  = 3'd0;
        bus.op_in = 3'b000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready_out !== 1'b0 || bus.resp_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: ready=%b valid=%b, required 0 0",
                     bus.req_ready_out, bus.resp_valid_out);
        end
        checks++;
        if (bus.y_out !== 8'h00 || bus.zf_out !== 1'b0 || bus.vf_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: y=%h zf=%b vf=%b, required 00 0 0",
                     bus.y_out, bus.zf_out, bus.vf_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b, required 1", bus.req_ready_out);
        end
    endtask

    task automatic test_lsr_asr();
        run_op(8'hB4, 3, 3'b000, mk(8'h16, 1'b0, 1'b0), "lsr_b4_3");
        run_op(8'hB4, 3, 3'b001, mk(8'hF6, 1'b0, 1'b0), "asr_b4_3");
    endtask

    task automatic test_rotate();
        run_op(8'h01, 7, 3'b010, mk(8'h02, 1'b0, 1'b0), "ror_01_7");
        run_op(8'h81, 1, 3'b110, mk(8'h03, 1'b0, 1'b0), "rol_81_1");
        run_op(8'h01, 1, 3'b011, mk(8'h80, 1'b0, 1'b0), "ror_alias");
        run_op(8'h80, 1, 3'b111, mk(8'h01, 1'b0, 1'b0), "rol_alias");
    endtask

    task automatic test_asl();
        run_op(8'h1F, 3, 3'b101, mk(8'h78, 1'b0, 1'b1), "asl_1f_3");
        run_op(8'hF1, 2, 3'b101, mk(8'hC4, 1'b0, 1'b0), "asl_f1_2");
        run_op(8'h40, 0, 3'b101, mk(8'h40, 1'b0, 1'b0), "asl_40_0");
        run_op(8'h40, 1, 3'b101, mk(8'h00, 1'b1, 1'b1), "asl_40_1");
    endtask

    task automatic test_zero();
        run_op(8'h80, 1, 3'b100, mk(8'h00, 1'b1, 1'b0), "lsl_80_1");
        run_op(8'h00, 0, 3'b000, mk(8'h00, 1'b1, 1'b0), "lsr_00_0");
    endtask

    task automatic test_random();
        logic [7:0] x;
        logic [2:0] op;
        int         s;
        for (int i = 0; i < 30; i++) begin
            x  = 8'($urandom);
            s  = $urandom_range(0, 7);
            op = 3'($urandom_range(0, 7));
            run_op(x, s, op, model(x, s, op), "random");
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        sb.push_back(mk(8'h14, 1'b0, 1'b0));
        send(8'h05, 2, 3'b100, ok);
        if (!ok) return;
        wait_and_check(2, "bp_first");
        sb.push_back(mk(8'h1E, 1'b0, 1'b0));
        bus.req_valid_in = 1'b1;
        bus.x_in  = 8'h3C;
        bus.s_in  = 3'd1;
        bus.op_in = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.y_out !== 8'h14 || bus.zf_out !== 1'b0 || bus.vf_out !== 1'b0 ||
                bus.resp_valid_out !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold: y=%h zf=%b vf=%b valid=%b, required 14 0 0 1",
                         bus.y_out, bus.zf_out, bus.vf_out, bus.resp_valid_out);
            end
            checks++;
            if (bus.req_ready_out !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready: got %b, required 0", bus.req_ready_out);
            end
        end
        handshake("bp_first");
        send(8'h3C, 1, 3'b000, ok);
        if (ok) begin
            wait_and_check(1, "bp_second");
            handshake("bp_second");
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit stale;
        sb.push_back(mk(8'h01, 1'b0, 1'b0));
        send(8'hFF, 7, 3'b000, ok);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.resp_valid_out !== 1'b0 || bus.req_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL midreset_handshake: valid=%b ready=%b, required 0 0",
                     bus.resp_valid_out, bus.req_ready_out);
        end
        checks++;
        if (bus.y_out !== 8'h00 || bus.zf_out !== 1'b0 || bus.vf_out !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: y=%h zf=%b vf=%b, required 00 0 0",
                     bus.y_out, bus.zf_out, bus.vf_out);
        end
        sb.delete();
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.resp_valid_out !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("FAIL midreset_stale: resp_valid_out seen 1, required 0 after reset");
        end
        run_op(8'hB4, 3, 3'b001, mk(8'hF6, 1'b0, 1'b0), "post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lsr_asr();
        test_rotate();
        test_asl();
        test_zero();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
